// File: rtl/pid_pkg.sv
// pid_pkg: definitions shared by the PID sequencer and the integral stage.
//   N_DEF        default data width of yk/rk/ik/uk
//   INT_PIPE_LAT register depth of the integral stage (yk/rk stable -> sum valid)
//   state_t      sequencer FSM states
package pid_pkg;

  localparam int N_DEF        = 8;
  localparam int INT_PIPE_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ADC,
    LOAD,
    PIPE,
    UPD_IK,
    UPD_IK1,
    OUT
  } state_t;

endpackage

// File: rtl/pid_tick_gen.sv
// pid_tick_gen: sample-period divider for the PID sequencer.
// Ports:
//   clk   in  system clock, rising edge
//   reset in  asynchronous active-high reset
//   start in  1 = count 0..TS_DIV-1 and wrap, 0 = hold count at 0
//   tick  out high in the cycle the count equals TS_DIV-1 (while start=1)
module pid_tick_gen #(
  parameter int TS_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic tick
);

  localparam int CW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(TS_DIV - 1));
  assign tick   = start && at_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt <= '0;
    else if (!start || at_end) cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/pid_seq_ctrl.sv
// pid_seq_ctrl: control sequencer upstream of the PID integral-term stage.
// Each sample tick: request an ADC conversion, latch measurement/setpoint onto
// yk/rk, wait out the integral pipeline, strobe enable_ik then enable_ik_1,
// and capture ik_in as uk_out with a one-cycle uk_valid. All outputs registered.
// Ports:
//   clk, reset            clock (rising) / asynchronous active-high reset
//   start                 level: 1 = free-run sampling, 0 = stop after current sequence
//   adc_data, adc_valid   conversion result and its single-cycle strobe
//   setpoint              reference, sampled in LOAD
//   ik_in                 integral-stage result
//   adc_req               single-cycle conversion request
//   yk, rk                registered measurement / reference to the integral stage
//   enable_ik, enable_ik_1 one-cycle strobes to the integral stage
//   uk_out, uk_valid      controller output and its one-cycle valid pulse
//   busy                  FSM not in IDLE
//   overrun, adc_err      sticky: tick while busy / ADC timeout
//   ovr_count             saturating overrun count; built only when
//                         PID_SEQ_OVR_COUNT_EN is defined, otherwise tied to 0
module pid_seq_ctrl
  import pid_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int PIPE_LAT = INT_PIPE_LAT,
  parameter int TS_DIV   = 100,
  parameter int ADC_TO   = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] adc_data,
  input  logic         adc_valid,
  input  logic [N-1:0] setpoint,
  input  logic [N-1:0] ik_in,
  output logic         adc_req,
  output logic [N-1:0] yk,
  output logic [N-1:0] rk,
  output logic         enable_ik,
  output logic         enable_ik_1,
  output logic [N-1:0] uk_out,
  output logic         uk_valid,
  output logic         busy,
  output logic         overrun,
  output logic         adc_err,
  output logic [7:0]   ovr_count
);

  localparam int CMAX = (ADC_TO > PIPE_LAT) ? ADC_TO : PIPE_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  adc_hold;
  logic          tick, timeout, ovr_evt;

  pid_tick_gen #(.TS_DIV(TS_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .tick  (tick)
  );

  // One counter serves both the ADC wait and the pipeline wait; it is cleared
  // on the cycle before each of those states is entered.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    timeout = 1'b0;
    case (state)
      IDLE:     if (tick) nxt = REQ;
      REQ: begin
        nxt     = WAIT_ADC;
        cnt_nxt = '0;
      end
      WAIT_ADC: begin
        if (adc_valid) begin
          nxt = LOAD;
        end else if (cnt == CW'(ADC_TO - 1)) begin
          nxt     = IDLE;
          timeout = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      LOAD: begin
        nxt     = PIPE;
        cnt_nxt = '0;
      end
      PIPE: begin
        if (cnt == CW'(PIPE_LAT - 1)) nxt = UPD_IK;
        else                          cnt_nxt = cnt + CW'(1);
      end
      UPD_IK:   nxt = UPD_IK1;
      UPD_IK1:  nxt = OUT;
      OUT:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    // Ticks arriving while busy (including the OUT cycle) are dropped.
    ovr_evt = tick && (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Control outputs are decoded from the next state so each is a register
  // that is high exactly while the FSM sits in the corresponding state.
  // adc_data is only valid alongside adc_valid, so it is held internally and
  // moved to yk together with rk at the LOAD edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_req     <= 1'b0;
      enable_ik   <= 1'b0;
      enable_ik_1 <= 1'b0;
      uk_valid    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      adc_err     <= 1'b0;
      adc_hold    <= '0;
      yk          <= '0;
      rk          <= '0;
      uk_out      <= '0;
    end else begin
      adc_req     <= (nxt == REQ);
      enable_ik   <= (nxt == UPD_IK);
      enable_ik_1 <= (nxt == UPD_IK1);
      uk_valid    <= (nxt == OUT);
      busy        <= (nxt != IDLE);
      if (timeout) adc_err <= 1'b1;
      if (ovr_evt) overrun <= 1'b1;
      if (state == WAIT_ADC && adc_valid) adc_hold <= adc_data;
      if (state == LOAD) begin
        yk <= adc_hold;
        rk <= setpoint;
      end
      if (state == UPD_IK1) uk_out <= ik_in;
    end
  end

`ifdef PID_SEQ_OVR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              ovr_count <= '0;
    else if (ovr_evt && ovr_count != 8'hFF) ovr_count <= ovr_count + 8'd1;
  end
`else
  assign ovr_count = '0;
`endif

endmodule

// File: tb/tb_pid_seq_ctrl.sv
// tb_pid_seq_ctrl: directed self-checking bench for pid_seq_ctrl with a
// scoreboard of expected uk values (pushed when adc_valid is driven, popped
// on uk_valid).
module tb_pid_seq_ctrl;

  localparam int N  = 8;
  localparam int TS = 20;
  localparam int PL = 2;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset, start, adc_valid;
  logic [N-1:0] adc_data, setpoint, ik_in;
  logic         adc_req, enable_ik, enable_ik_1, uk_valid, busy, overrun, adc_err;
  logic [N-1:0] yk, rk, uk_out;
  logic [7:0]   ovr_count;

  always #5 clk = ~clk;

  pid_seq_ctrl #(.N(N), .PIPE_LAT(PL), .TS_DIV(TS), .ADC_TO(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .setpoint    (setpoint),
    .ik_in       (ik_in),
    .adc_req     (adc_req),
    .yk          (yk),
    .rk          (rk),
    .enable_ik   (enable_ik),
    .enable_ik_1 (enable_ik_1),
    .uk_out      (uk_out),
    .uk_valid    (uk_valid),
    .busy        (busy),
    .overrun     (overrun),
    .adc_err     (adc_err),
    .ovr_count   (ovr_count)
  );

  int         checks = 0, failures = 0;
  int         cyc = 0, last_req = 0;
  int         n_req = 0, n_eik = 0, n_eik1 = 0, n_ukv = 0;
  logic [7:0] sbq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample #1 after the edge; counts strobes and
  // retires scoreboard entries on uk_valid.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (adc_req)     n_req++;
    if (enable_ik)   n_eik++;
    if (enable_ik_1) n_eik1++;
    check("strobe_excl", {31'b0, enable_ik & enable_ik_1}, 32'd0);
    if (uk_valid) begin
      n_ukv++;
      if (sbq.size() == 0) check("uk_unexpected", {31'b0, uk_valid}, 32'd0);
      else                 check("uk_out", {24'b0, uk_out}, {24'b0, sbq.pop_front()});
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", {25'b0, adc_req, enable_ik, enable_ik_1, uk_valid, busy, overrun, adc_err}, 32'd0);
    check("rst_data", {8'b0, yk, rk, uk_out}, 32'd0);
    check("rst_ovr", {24'b0, ovr_count}, 32'd0);
  endtask

  // Step until adc_req, then check the spacing from the previous reference.
  task automatic wait_req(input int budget, input int period);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (adc_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_timeout", {31'b0, adc_req}, 32'd1);
    else     check("req_period", cyc - last_req, period);
    last_req = cyc;
  endtask

  // Return adc_valid `delay` cycles from now; ends at A+2 after checking yk/rk.
  task automatic serve(input int delay, input logic [7:0] y, input logic [7:0] r, input logic [7:0] ik);
    setpoint = r;
    ik_in    = ik;
    steps(delay);
    adc_valid = 1'b1;
    adc_data  = y;
    sbq.push_back(ik);
    step();
    adc_valid = 1'b0;
    adc_data  = ~y;
    step();
    check("yk", {24'b0, yk}, {24'b0, y});
    check("rk", {24'b0, rk}, {24'b0, r});
  endtask

  // From A+2: enable_ik at A+4, enable_ik_1 at A+5, uk_valid at A+6, idle at A+7.
  task automatic finish_seq();
    step();
    check("eik_early", {31'b0, enable_ik}, 32'd0);
    step();
    check("eik", {30'b0, enable_ik, enable_ik_1}, 32'd2);
    step();
    check("eik1", {30'b0, enable_ik, enable_ik_1}, 32'd1);
    step();
    check("uk_valid", {31'b0, uk_valid}, 32'd1);
    step();
    check("post_idle", {30'b0, uk_valid, busy}, 32'd0);
  endtask

  initial begin
    int r0, e0, e10, u0;
    logic [7:0] ovr_exp;
`ifdef PID_SEQ_OVR_COUNT_EN
    ovr_exp = 8'd1;
`else
    ovr_exp = 8'd0;
`endif
    reset = 1'b1; start = 1'b0; adc_valid = 1'b0;
    adc_data = '0; setpoint = '0; ik_in = '0;
    steps(3);
    check_reset_outputs();

    // Nominal sequence; first request TS cycles after release.
    reset = 1'b0; start = 1'b1; last_req = cyc;
    wait_req(40, TS);
    check("busy_req", {31'b0, busy}, 32'd1);
    serve(3, 8'h10, 8'h05, 8'h2A);
    finish_seq();

    // Periodicity over five sample periods.
    r0 = n_req; e0 = n_eik; e10 = n_eik1; u0 = n_ukv;
    for (int i = 0; i < 5; i++) begin
      wait_req(40, TS);
      serve(3, 8'($urandom), 8'($urandom), 8'($urandom));
      finish_seq();
    end
    check("per_req", n_req - r0, 5);
    check("per_ukv", n_ukv - u0, 5);
    check("per_eik", n_eik - e0, 5);
    check("per_eik1", n_eik1 - e10, 5);
    check("per_ovr", {31'b0, overrun}, 32'd0);

    // ADC timeout: no adc_valid.
    wait_req(40, TS);
    e0 = n_eik; e10 = n_eik1; u0 = n_ukv;
    steps(15);
    check("to_err_early", {30'b0, adc_err, busy}, 32'd1);
    step();
    check("to_err", {30'b0, adc_err, busy}, 32'd2);
    wait_req(40, TS);
    check("to_eik", n_eik - e0, 0);
    check("to_eik1", n_eik1 - e10, 0);
    check("to_ukv", n_ukv - u0, 0);
    serve(3, 8'h3C, 8'h11, 8'h99);
    finish_seq();
    check("to_sticky", {31'b0, adc_err}, 32'd1);

    // Overrun: slow ADC pushes the sequence across the next tick.
    wait_req(40, TS);
    serve(15, 8'hA5, 8'h5A, 8'hC3);
    check("ovr_before", {31'b0, overrun}, 32'd0);
    finish_seq();
    check("ovr_flag", {31'b0, overrun}, 32'd1);
    check("ovr_count", {24'b0, ovr_count}, {24'b0, ovr_exp});
    wait_req(60, 2 * TS);
    serve(3, 8'h01, 8'h02, 8'h03);
    finish_seq();

    // Reset during PIPE aborts the sequence.
    wait_req(40, TS);
    serve(3, 8'h77, 8'h66, 8'h55);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    sbq.delete();
    e0 = n_eik;
    steps(2);
    reset = 1'b0; last_req = cyc;
    wait_req(40, TS);
    check("rst_no_eik", n_eik - e0, 0);

    // Stop: start dropped during WAIT_ADC; sequence completes, no more requests.
    step();
    start = 1'b0;
    u0 = n_ukv;
    serve(2, 8'h42, 8'h24, 8'hE7);
    finish_seq();
    check("stop_ukv", n_ukv - u0, 1);
    r0 = n_req;
    steps(50);
    check("stop_noreq", n_req - r0, 0);
    check("stop_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
